move_sequencer: RTL

- Sits between the keyboard decoder / gravity timer and the test-position/collision path.
- Captures move requests (gravity tick, left, right, rotate, soft-down, hard-drop) and arbitrates them by fixed priority.
- Issues one candidate move at a time over a valid/done handshake to the test-position + collision checker, then emits commit, reject or lock strobes.
- Sequences hard drop as repeated down-steps until the checker fails.

---
 rtl/move_sequencer_if.sv | 11 +
 rtl/move_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/move_sequencer_if.sv
// Candidate-move handshake between the move sequencer and the test-position/collision checker.
// The sequencer drives the candidate; the checker answers with a one-cycle done/ok result.
interface move_sequencer_if;
    logic       test_valid;
    logic [2:0] test_op;
    logic       chk_done;
    logic       chk_ok;

    modport master (output test_valid, test_op, input chk_done, chk_ok);
    modport slave  (input test_valid, test_op, output chk_done, chk_ok);
endinterface

// File: rtl/move_sequencer.sv
// Move sequencer: captures gravity/key move requests, arbitrates by fixed priority and runs
// one candidate at a time through the collision checker, including multi-step hard drops.
`ifndef MODE_BITS
`define MODE_BITS 2
`endif
`ifndef MODE_PLAY
`define MODE_PLAY 2'd1
`endif

module move_sequencer #(
    parameter int TIMEOUT  = 15,
    parameter int DROP_MAX = 24,
    parameter int CNT_BITS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [`MODE_BITS-1:0] mode,
    input  logic                  gravity_tick,
    input  logic                  been_ready,
    input  logic [511:0]          key_down,
    input  logic [8:0]            last_change,
    move_sequencer_if.master      chk,
    output logic                  commit,
    output logic                  reject,
    output logic                  lock,
    output logic                  drop_active,
    output logic                  timeout_err
);

    typedef enum logic [2:0] {
        OP_NONE      = 3'd0,
        OP_GRAV      = 3'd1,
        OP_LEFT      = 3'd2,
        OP_RIGHT     = 3'd3,
        OP_ROT       = 3'd4,
        OP_DOWN      = 3'd5,
        OP_DROP_STEP = 3'd6
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // Flag index i maps to op i+1, and a lower index wins arbitration.
    localparam int NUM_FLAGS = 6;
    localparam int F_GRAV    = 0;
    localparam int F_LEFT    = 1;
    localparam int F_RIGHT   = 2;
    localparam int F_ROT     = 3;
    localparam int F_DOWN    = 4;
    localparam int F_DROP    = 5;

    localparam logic [8:0] CODE_LEFT  = 9'h01C;
    localparam logic [8:0] CODE_RIGHT = 9'h023;
    localparam logic [8:0] CODE_ROT   = 9'h01D;
    localparam logic [8:0] CODE_DOWN  = 9'h01B;
    localparam logic [8:0] CODE_DROP  = 9'h029;

    localparam logic [CNT_BITS-1:0] TMO_LAST = CNT_BITS'(TIMEOUT - 1);
    localparam logic [CNT_BITS-1:0] DROP_LIM = CNT_BITS'(DROP_MAX);

    state_t                state_reg, state_next;
    op_t                   op_reg, op_next;
    logic [NUM_FLAGS-1:0]  pending_reg, pending_next;
    logic [CNT_BITS-1:0]   tmo_cnt_reg, tmo_cnt_next;
    logic [CNT_BITS-1:0]   drop_cnt_reg, drop_cnt_next;
    logic                  drop_active_reg, drop_active_next;
    logic                  been_ready_prev_reg;
    logic                  commit_reg, commit_next;
    logic                  reject_reg, reject_next;
    logic                  lock_reg, lock_next;
    logic                  timeout_reg, timeout_next;

    logic                  play;
    logic                  key_rise;
    logic [NUM_FLAGS-1:0]  set_mask;
    logic [NUM_FLAGS-1:0]  grant_mask;
    op_t                   grant_op;

    assign play     = (mode == `MODE_PLAY);
    assign key_rise = been_ready & ~been_ready_prev_reg & key_down[last_change];

    // Requests are not captured while a hard drop owns the piece.
    always_comb begin
        set_mask = '0;
        if (!drop_active_reg) begin
            set_mask[F_GRAV] = gravity_tick;
            if (key_rise) begin
                case (last_change)
                    CODE_LEFT:  set_mask[F_LEFT]  = 1'b1;
                    CODE_RIGHT: set_mask[F_RIGHT] = 1'b1;
                    CODE_ROT:   set_mask[F_ROT]   = 1'b1;
                    CODE_DOWN:  set_mask[F_DOWN]  = 1'b1;
                    CODE_DROP:  set_mask[F_DROP]  = 1'b1;
                    default:    ;
                endcase
            end
        end
    end

    assign grant_mask[0] = pending_reg[0];
    generate
        for (genvar gi = 1; gi < NUM_FLAGS; gi++) begin : g_prio
            assign grant_mask[gi] = pending_reg[gi] & ~|pending_reg[gi-1:0];
        end
    endgenerate

    always_comb begin
        grant_op = OP_NONE;
        for (int i = 0; i < NUM_FLAGS; i++) begin
            if (grant_mask[i]) grant_op = op_t'(3'(i + 1));
        end
    end

    always_comb begin
        state_next       = state_reg;
        op_next          = op_reg;
        pending_next     = pending_reg | set_mask;
        tmo_cnt_next     = tmo_cnt_reg;
        drop_cnt_next    = drop_cnt_reg;
        drop_active_next = drop_active_reg;
        commit_next      = 1'b0;
        reject_next      = 1'b0;
        lock_next        = 1'b0;
        timeout_next     = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                tmo_cnt_next = '0;
                if (play && (|pending_reg)) begin
                    op_next      = grant_op;
                    state_next   = ST_WAIT;
                    pending_next = (pending_reg & ~grant_mask) | set_mask;
                    if (grant_mask[F_DROP]) begin
                        drop_active_next = 1'b1;
                        drop_cnt_next    = '0;
                        pending_next     = '0;
                    end
                end
            end

            ST_WAIT: begin
                tmo_cnt_next = tmo_cnt_reg + 1'b1;
                if (chk.chk_done) begin
                    tmo_cnt_next = '0;
                    if (chk.chk_ok) begin
                        commit_next = 1'b1;
                        if (op_reg == OP_DROP_STEP) begin
                            drop_cnt_next = drop_cnt_reg + 1'b1;
                            state_next    = ST_GAP;
                        end else begin
                            state_next = ST_IDLE;
                            op_next    = OP_NONE;
                        end
                    end else begin
                        state_next = ST_IDLE;
                        op_next    = OP_NONE;
                        if (op_reg == OP_GRAV || op_reg == OP_DROP_STEP) begin
                            lock_next        = 1'b1;
                            drop_active_next = 1'b0;
                        end else begin
                            reject_next = 1'b1;
                        end
                    end
                end else if (tmo_cnt_reg == TMO_LAST) begin
                    // The abandoned candidate is dropped, not retried.
                    timeout_next     = 1'b1;
                    drop_active_next = 1'b0;
                    tmo_cnt_next     = '0;
                    state_next       = ST_IDLE;
                    op_next          = OP_NONE;
                end
            end

            ST_GAP: begin
                // One idle cycle between drop steps; the commit pulse is out now,
                // so a forced lock here stays exclusive with it.
                if (drop_cnt_reg == DROP_LIM) begin
                    lock_next        = 1'b1;
                    drop_active_next = 1'b0;
                    state_next       = ST_IDLE;
                    op_next          = OP_NONE;
                end else begin
                    state_next = ST_WAIT;
                end
            end

            default: begin
                state_next = ST_IDLE;
                op_next    = OP_NONE;
            end
        endcase

        if (!play && !drop_active_reg) pending_next = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg           <= ST_IDLE;
            op_reg              <= OP_NONE;
            pending_reg         <= '0;
            tmo_cnt_reg         <= '0;
            drop_cnt_reg        <= '0;
            drop_active_reg     <= 1'b0;
            been_ready_prev_reg <= 1'b0;
            commit_reg          <= 1'b0;
            reject_reg          <= 1'b0;
            lock_reg            <= 1'b0;
            timeout_reg         <= 1'b0;
        end else begin
            state_reg           <= state_next;
            op_reg              <= op_next;
            pending_reg         <= pending_next;
            tmo_cnt_reg         <= tmo_cnt_next;
            drop_cnt_reg        <= drop_cnt_next;
            drop_active_reg     <= drop_active_next;
            been_ready_prev_reg <= been_ready;
            commit_reg          <= commit_next;
            reject_reg          <= reject_next;
            lock_reg            <= lock_next;
            timeout_reg         <= timeout_next;
        end
    end

    assign chk.test_valid = (state_reg == ST_WAIT);
    assign chk.test_op    = op_reg;
    assign commit         = commit_reg;
    assign reject         = reject_reg;
    assign lock           = lock_reg;
    assign drop_active    = drop_active_reg;
    assign timeout_err    = timeout_reg;

endmodule
